// File: rtl/smc_soc_cpu_oci_pkg.sv
// ---------------------------------------------------------------------------
// smc_soc_cpu_oci_pkg
//   Shared constants and types for the OCI direction/condition trace (DCT)
//   packer: frame geometry, frame type codes, packer state enum and the
//   frame layout struct.
//
//   Optional feature macro: SMC_OCI_DCT_TIMESTAMP_EN
//     When defined, every frame carries a TS_W-bit timestamp in its most
//     significant bits and FRAME_W grows by TS_W.
// ---------------------------------------------------------------------------
package smc_soc_cpu_oci_pkg;

  localparam int DCT_SLOTS = 15;                  // codes per frame
  localparam int CODE_W    = 2;                   // bits per trace code
  localparam int TS_W      = 16;                  // timestamp width
  localparam int BUF_W     = DCT_SLOTS * CODE_W;  // 30-bit shift buffer
  localparam int CNT_W     = 4;                   // holds 0..15
  localparam int TYPE_W    = 4;

  localparam logic [TYPE_W-1:0] DCT_T_NORM = 4'h1;
  localparam logic [TYPE_W-1:0] DCT_T_OVF  = 4'h9;
  localparam logic [CNT_W-1:0]  DCT_FULL   = CNT_W'(DCT_SLOTS);

`ifdef SMC_OCI_DCT_TIMESTAMP_EN
  localparam int FRAME_W = TS_W + TYPE_W + CNT_W + BUF_W;
`else
  localparam int FRAME_W = TYPE_W + CNT_W + BUF_W;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } dct_state_e;

  // Field order is MSB first: timestamp (optional), type, count, buffer.
  typedef struct packed {
`ifdef SMC_OCI_DCT_TIMESTAMP_EN
    logic [TS_W-1:0]   ts;
`endif
    logic [TYPE_W-1:0] ftype;
    logic [CNT_W-1:0]  count;
    logic [BUF_W-1:0]  buffer;
  } dct_frame_t;

  // Frame type reflects whether any code was lost since the last frame.
  function automatic logic [TYPE_W-1:0] dct_frame_type(input logic ovf);
    return ovf ? DCT_T_OVF : DCT_T_NORM;
  endfunction

endpackage

// File: rtl/smc_soc_cpu_oci_dct_outreg.sv
// ---------------------------------------------------------------------------
// smc_soc_cpu_oci_dct_outreg
//   One-entry valid/ready output register for completed DCT frames.
//   A frame is loaded only when the slot is free; the slot becomes free in
//   the same cycle the held frame is accepted, so back-to-back frames run
//   without a bubble.
//
//   Ports
//     clk          in   clock, rising edge
//     reset_n      in   synchronous reset, active-low (discards held frame)
//     i_load       in   load i_frame this cycle (only while o_slot_free)
//     i_frame      in   frame to load
//     i_ready      in   downstream accepts when o_valid & i_ready
//     o_valid      out  o_frame holds an un-accepted frame
//     o_frame      out  held frame, stable while o_valid & !i_ready
//     o_slot_free  out  a new frame may be loaded this cycle
// ---------------------------------------------------------------------------
module smc_soc_cpu_oci_dct_outreg
  import smc_soc_cpu_oci_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_load,
  input  dct_frame_t i_frame,
  input  logic       i_ready,
  output logic       o_valid,
  output dct_frame_t o_frame,
  output logic       o_slot_free
);

  logic       r_valid;
  dct_frame_t r_frame;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_frame <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_frame <= i_frame;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid     = r_valid;
  assign o_frame     = r_frame;
  assign o_slot_free = !r_valid || i_ready;

endmodule

// File: rtl/smc_soc_cpu_oci_dct_packer.sv
// ---------------------------------------------------------------------------
// smc_soc_cpu_oci_dct_packer
//   Packs 2-bit direction/condition trace codes from the Nios II OCI into
//   30-bit DCT frames (15 codes each) and hands completed frames to the trace
//   memory writer over a valid/ready port. The live buffer/count pair is
//   exposed for the OCI test-bench monitor.
//
//   Optional feature macro: SMC_OCI_DCT_TIMESTAMP_EN
//     Adds a free-running 16-bit cycle counter whose value is stamped into
//     frame_data[53:38] at emit time (frame_data becomes 54 bits).
//
//   Ports
//     clk          in   1    clock, rising edge
//     reset_n      in   1    synchronous reset, active-low
//     trc_on       in   1    trace enable; codes ignored while 0
//     code_valid   in   1    dct_code valid this cycle
//     dct_code     in   2    trace code
//     flush        in   1    pulse: emit the partial frame
//     dct_buffer   out  30   live shift buffer, newest code in [1:0]
//     dct_count    out  4    codes in dct_buffer (0..15)
//     frame_valid  out  1    frame_data holds an un-accepted frame
//     frame_ready  in   1    downstream accept
//     frame_data   out  38/54 {[ts,] type, count, buffer}
//     overflow     out  1    sticky: a code was dropped since last emit
// ---------------------------------------------------------------------------
module smc_soc_cpu_oci_dct_packer
  import smc_soc_cpu_oci_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               trc_on,
  input  logic               code_valid,
  input  logic [CODE_W-1:0]  dct_code,
  input  logic               flush,
  output logic [BUF_W-1:0]   dct_buffer,
  output logic [CNT_W-1:0]   dct_count,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic [FRAME_W-1:0] frame_data,
  output logic               overflow
);

  dct_state_e       r_state, w_state_next;
  logic [BUF_W-1:0] r_buffer, w_buffer_next;
  logic [CNT_W-1:0] r_count, w_count_next;
  logic             r_overflow, w_overflow_next;
  logic             r_flush_pend, w_flush_pend_next;
  logic             r_trc_on_d;

  logic             w_cap;
  logic             w_full;
  logic             w_slot_free;
  logic             w_emit;
  logic             w_drop;
  logic             w_drain_req;
  dct_frame_t       w_frame;
  dct_frame_t       w_frame_out;

`ifdef SMC_OCI_DCT_TIMESTAMP_EN
  logic [TS_W-1:0]  r_ts;

  // Free-running; natural 16-bit wrap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
    end
  end
`endif

  assign w_cap       = trc_on && code_valid;
  assign w_full      = (r_count == DCT_FULL);
  // A partial frame is emitted only once a drain is pending and there is
  // something to send; a full buffer always goes out when the slot frees.
  assign w_emit      = (w_full || (r_flush_pend && (r_count != '0))) && w_slot_free;
  assign w_drop      = w_cap && w_full && !w_slot_free;
  // Explicit flush or trace switching off both ask for the tail to be sent.
  assign w_drain_req = flush || (r_trc_on_d && !trc_on);

  // Buffer / count update
  always_comb begin
    w_buffer_next = r_buffer;
    w_count_next  = r_count;
    if (w_emit) begin
      // The emitted frame takes the old contents; a code in this cycle
      // becomes the first entry of the next frame.
      if (w_cap) begin
        w_buffer_next = {{(BUF_W-CODE_W){1'b0}}, dct_code};
        w_count_next  = CNT_W'(1);
      end else begin
        w_buffer_next = '0;
        w_count_next  = '0;
      end
    end else if (w_cap && !w_full) begin
      w_buffer_next = {r_buffer[BUF_W-CODE_W-1:0], dct_code};
      w_count_next  = r_count + CNT_W'(1);
    end
  end

  // Drop and emit are mutually exclusive (a drop needs a busy slot), so
  // the emit clear never hides a same-cycle drop.
  always_comb begin
    w_overflow_next = r_overflow;
    if (w_drop) begin
      w_overflow_next = 1'b1;
    end else if (w_emit) begin
      w_overflow_next = 1'b0;
    end
  end

  // A drain request is remembered only if the buffer will hold codes after
  // this edge; an empty buffer makes the request a no-op.
  always_comb begin
    w_flush_pend_next = r_flush_pend;
    if (w_emit || (r_count == '0)) begin
      w_flush_pend_next = 1'b0;
    end
    if (w_drain_req && (w_count_next != '0)) begin
      w_flush_pend_next = 1'b1;
    end
  end

  // Packer FSM next-state
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (trc_on) begin
          w_state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (w_drain_req) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_emit || !r_flush_pend) begin
          w_state_next = trc_on ? COLLECT : IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_buffer     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_flush_pend <= 1'b0;
      r_trc_on_d   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_buffer     <= w_buffer_next;
      r_count      <= w_count_next;
      r_overflow   <= w_overflow_next;
      r_flush_pend <= w_flush_pend_next;
      r_trc_on_d   <= trc_on;
    end
  end

  // Frame assembled from the pre-edge buffer state.
  always_comb begin
    w_frame        = '0;
    w_frame.ftype  = dct_frame_type(r_overflow);
    w_frame.count  = r_count;
    w_frame.buffer = r_buffer;
`ifdef SMC_OCI_DCT_TIMESTAMP_EN
    w_frame.ts     = r_ts;
`endif
  end

  smc_soc_cpu_oci_dct_outreg u_outreg (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_load      (w_emit),
    .i_frame     (w_frame),
    .i_ready     (frame_ready),
    .o_valid     (frame_valid),
    .o_frame     (w_frame_out),
    .o_slot_free (w_slot_free)
  );

  assign frame_data = w_frame_out;
  assign dct_buffer = r_buffer;
  assign dct_count  = r_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_smc_soc_cpu_oci_dct_packer.sv
// ---------------------------------------------------------------------------
// tb_smc_soc_cpu_oci_dct_packer
//   Directed bench for the DCT packer. Each task drives one scenario and
//   checks hand-computed values one edge at a time (sampled 1 ns after the
//   rising edge).
// ---------------------------------------------------------------------------
module tb_smc_soc_cpu_oci_dct_packer;
  import smc_soc_cpu_oci_pkg::*;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               trc_on;
  logic               code_valid;
  logic [1:0]         dct_code;
  logic               flush;
  logic [29:0]        dct_buffer;
  logic [3:0]         dct_count;
  logic               frame_valid;
  logic               frame_ready;
  logic [FRAME_W-1:0] frame_data;
  logic               overflow;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  smc_soc_cpu_oci_dct_packer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .trc_on      (trc_on),
    .code_valid  (code_valid),
    .dct_code    (dct_code),
    .flush       (flush),
    .dct_buffer  (dct_buffer),
    .dct_count   (dct_count),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .overflow    (overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; trc_on = 1'b0; code_valid = 1'b0;
    dct_code = 2'b00; flush = 1'b0; frame_ready = 1'b0;
    step(); step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (dct_count !== 4'd0 || dct_buffer !== 30'd0 || frame_valid !== 1'b0 ||
        overflow !== 1'b0 || frame_data !== '0) begin
      n_err++;
      $display("FAIL reset_init: cnt=%0d buf=%h fv=%b ovf=%b fd=%h, need all 0",
               dct_count, dct_buffer, frame_valid, overflow, frame_data);
    end
    trc_on = 1'b1; code_valid = 1'b1; dct_code = 2'b10;
    for (int i = 0; i < 7; i++) step();
    n_vec++;
    if (dct_count !== 4'd7 || dct_buffer !== 30'h2AAA) begin
      n_err++;
      $display("FAIL reset_precollect: cnt=%0d buf=%h, need 7 / 2aaa", dct_count, dct_buffer);
    end
    reset_n = 1'b0;
    step();
    n_vec++;
    if (dct_count !== 4'd0 || dct_buffer !== 30'd0 || frame_valid !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset_midcollect: cnt=%0d buf=%h fv=%b ovf=%b, need all 0",
               dct_count, dct_buffer, frame_valid, overflow);
    end
    $display("test_reset done");
  endtask

  task automatic test_full_frame();
    logic [37:0] exp;
    do_reset();
    frame_ready = 1'b1; trc_on = 1'b1; code_valid = 1'b1; dct_code = 2'b01;
    for (int i = 0; i < 15; i++) step();
    n_vec++;
    if (dct_count !== 4'd15 || dct_buffer !== 30'h15555555 || frame_valid !== 1'b0) begin
      n_err++;
      $display("FAIL full_fill: cnt=%0d buf=%h fv=%b, need 15 / 15555555 / 0",
               dct_count, dct_buffer, frame_valid);
    end
    code_valid = 1'b0;
    step();
    exp = {4'h1, 4'hF, 30'h15555555};
    n_vec++;
    if (frame_valid !== 1'b1 || frame_data[37:0] !== exp || dct_count !== 4'd0) begin
      n_err++;
      $display("FAIL full_emit: fv=%b fd=%h cnt=%0d, need 1 / %h / 0",
               frame_valid, frame_data[37:0], dct_count, exp);
    end
    step();
    n_vec++;
    if (frame_valid !== 1'b0) begin
      n_err++;
      $display("FAIL full_accept: fv=%b, need 0", frame_valid);
    end
    $display("test_full_frame done");
  endtask

  task automatic test_flush();
    logic [37:0] exp;
    do_reset();
    frame_ready = 1'b1; trc_on = 1'b1; code_valid = 1'b1;
    dct_code = 2'b11; step();
    dct_code = 2'b10; step();
    dct_code = 2'b01; step();
    code_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    exp = {4'h1, 4'h3, 30'h39};
    n_vec++;
    if (frame_valid !== 1'b1 || frame_data[37:0] !== exp || dct_count !== 4'd0) begin
      n_err++;
      $display("FAIL flush_partial: fv=%b fd=%h cnt=%0d, need 1 / %h / 0",
               frame_valid, frame_data[37:0], dct_count, exp);
    end
    step();
    flush = 1'b1; step();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (frame_valid !== 1'b0 || dct_count !== 4'd0) begin
        n_err++;
        $display("FAIL flush_empty: fv=%b cnt=%0d, need 0 / 0", frame_valid, dct_count);
      end
    end
    $display("test_flush done");
  endtask

  task automatic test_backpressure();
    logic [37:0] exp1, exp2;
    do_reset();
    frame_ready = 1'b0; trc_on = 1'b1; code_valid = 1'b1;
    dct_code = 2'b11;
    for (int i = 0; i < 15; i++) step();
    dct_code = 2'b10;
    for (int i = 0; i < 15; i++) step();
    exp1 = {4'h1, 4'hF, 30'h3FFFFFFF};
    n_vec++;
    if (frame_valid !== 1'b1 || frame_data[37:0] !== exp1 || dct_count !== 4'd15 ||
        dct_buffer !== 30'h2AAAAAAA) begin
      n_err++;
      $display("FAIL bp_hold: fv=%b fd=%h cnt=%0d buf=%h, need 1 / %h / 15 / 2aaaaaaa",
               frame_valid, frame_data[37:0], dct_count, dct_buffer, exp1);
    end
    dct_code = 2'b01;
    step();
    n_vec++;
    if (overflow !== 1'b1 || dct_count !== 4'd15 || dct_buffer !== 30'h2AAAAAAA ||
        frame_data[37:0] !== exp1) begin
      n_err++;
      $display("FAIL bp_drop: ovf=%b cnt=%0d buf=%h fd=%h, need 1 / 15 / 2aaaaaaa / %h",
               overflow, dct_count, dct_buffer, frame_data[37:0], exp1);
    end
    code_valid = 1'b0; frame_ready = 1'b1;
    step();
    exp2 = {4'h9, 4'hF, 30'h2AAAAAAA};
    n_vec++;
    if (frame_valid !== 1'b1 || frame_data[37:0] !== exp2 || overflow !== 1'b0 ||
        dct_count !== 4'd0) begin
      n_err++;
      $display("FAIL bp_ovf_frame: fv=%b fd=%h ovf=%b cnt=%0d, need 1 / %h / 0 / 0",
               frame_valid, frame_data[37:0], overflow, dct_count, exp2);
    end
    step();
    n_vec++;
    if (frame_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_drain: fv=%b, need 0", frame_valid);
    end
    $display("test_backpressure done");
  endtask

  task automatic test_back_to_back();
    logic [37:0] exp;
    do_reset();
    frame_ready = 1'b1; trc_on = 1'b1; code_valid = 1'b1;
    dct_code = 2'b00;
    for (int i = 0; i < 15; i++) step();
    dct_code = 2'b11;
    step();
    exp = {4'h1, 4'hF, 30'h0};
    n_vec++;
    if (dct_count !== 4'd1 || dct_buffer !== 30'h3 || frame_valid !== 1'b1 ||
        frame_data[37:0] !== exp) begin
      n_err++;
      $display("FAIL b2b_emit_code: cnt=%0d buf=%h fv=%b fd=%h, need 1 / 3 / 1 / %h",
               dct_count, dct_buffer, frame_valid, frame_data[37:0], exp);
    end
    dct_code = 2'b01;
    for (int i = 0; i < 4; i++) step();
    n_vec++;
    if (dct_count !== 4'd5 || dct_buffer !== 30'h355 || frame_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_fill5: cnt=%0d buf=%h fv=%b, need 5 / 355 / 0",
               dct_count, dct_buffer, frame_valid);
    end
    trc_on = 1'b0; code_valid = 1'b0;
    step();
    step();
    exp = {4'h1, 4'h5, 30'h355};
    n_vec++;
    if (frame_valid !== 1'b1 || frame_data[37:0] !== exp || dct_count !== 4'd0) begin
      n_err++;
      $display("FAIL b2b_trc_off: fv=%b fd=%h cnt=%0d, need 1 / %h / 0",
               frame_valid, frame_data[37:0], dct_count, exp);
    end
    $display("test_back_to_back done");
  endtask

`ifdef SMC_OCI_DCT_TIMESTAMP_EN
  task automatic test_timestamp();
    logic [15:0] ts_got;
    do_reset();
    frame_ready = 1'b1;
    // Counter reads j-1 before the j-th edge after reset; emit on edge 70001.
    for (int i = 0; i < 69985; i++) step();
    trc_on = 1'b1; code_valid = 1'b1; dct_code = 2'b10;
    for (int i = 0; i < 15; i++) step();
    code_valid = 1'b0;
    step();
    ts_got = frame_data[53:38];
    n_vec++;
    if (frame_valid !== 1'b1 || ts_got !== 16'd4464) begin
      n_err++;
      $display("FAIL ts_wrap: fv=%b ts=%0d, need 1 / 4464", frame_valid, ts_got);
    end
    $display("test_timestamp done");
  endtask
`endif

  initial begin
    test_reset();
    test_full_frame();
    test_flush();
    test_backpressure();
    test_back_to_back();
`ifdef SMC_OCI_DCT_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
